// File: rtl/encode_opnd_bytes_pkg.sv
// Shared definitions for the operand byte encoder: operand form codes,
// encoder FSM states, maximum instruction length and the derived-length
// helper that is also used by the decoder bench.
package encode_opnd_bytes_pkg;

    localparam int MAX_INSTR_LEN = 11;

    localparam logic [3:0] OPND_ENC_NONE                = 4'd0;
    localparam logic [3:0] OPND_ENC_IMM                 = 4'd1;
    localparam logic [3:0] OPND_ENC_REG_IMM             = 4'd2;
    localparam logic [3:0] OPND_ENC_EAX_IMM             = 4'd3;
    localparam logic [3:0] OPND_ENC_DISP8               = 4'd4;
    localparam logic [3:0] OPND_ENC_DISP32              = 4'd5;
    localparam logic [3:0] OPND_ENC_MODREGRM_RM         = 4'd6;
    localparam logic [3:0] OPND_ENC_MODREGRM_RM_IMM     = 4'd7;
    localparam logic [3:0] OPND_ENC_MODREGRM_RM_REG     = 4'd8;
    localparam logic [3:0] OPND_ENC_MODREGRM_RM_REG_IMM = 4'd9;
    localparam logic [3:0] OPND_ENC_MODREGRM_RM_REG_CL  = 4'd10;
    localparam logic [3:0] OPND_ENC_MODREGRM_RM_CL      = 4'd11;
    localparam logic [3:0] OPND_ENC_MODREGRM_REG_RM     = 4'd12;
    localparam logic [3:0] OPND_ENC_MODREGRM_REG_RM_IMM = 4'd13;
    localparam logic [3:0] OPND_ENC_REG                 = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OPC   = 3'd1,
        ST_MODRM = 3'd2,
        ST_SIB   = 3'd3,
        ST_DISP  = 3'd4,
        ST_IMM   = 3'd5
    } enc_state_t;

    typedef struct packed {
        logic       has_modrm;
        logic       has_sib;
        logic [2:0] disp_len;
        logic [2:0] imm_len;
        logic [3:0] instr_len;
    } opnd_len_t;

    // Field presence and byte counts for one instruction; exact inverse of
    // the operand decoder's length rules.
    function automatic opnd_len_t calc_opnd_len(
        input logic [3:0] form,
        input logic [1:0] md,
        input logic [2:0] rm,
        input logic [2:0] sib_base,
        input logic       addr16,
        input logic       opnd16,
        input logic       imm8
    );
        opnd_len_t r;
        logic      direct;
        logic      d32;
        logic      d8;
        logic      has_imm;
        r.has_modrm = form inside {OPND_ENC_MODREGRM_RM, OPND_ENC_MODREGRM_RM_IMM,
                                   OPND_ENC_MODREGRM_RM_REG, OPND_ENC_MODREGRM_RM_REG_IMM,
                                   OPND_ENC_MODREGRM_RM_REG_CL, OPND_ENC_MODREGRM_RM_CL,
                                   OPND_ENC_MODREGRM_REG_RM, OPND_ENC_MODREGRM_REG_RM_IMM};
        direct      = r.has_modrm && (md == 2'b11);
        r.has_sib   = r.has_modrm && !addr16 && !direct && (rm == 3'b100);
        d32 = (form == OPND_ENC_DISP32)
            || (r.has_modrm && !direct && ((rm == 3'b101 && md == 2'b00) || md == 2'b10))
            || (r.has_sib && sib_base == 3'b101 && (md == 2'b00 || md == 2'b10));
        d8  = (form == OPND_ENC_DISP8) || (r.has_modrm && md == 2'b01);
        r.disp_len = d32 ? 3'd4 : (d8 ? 3'd1 : 3'd0);
        has_imm = form inside {OPND_ENC_IMM, OPND_ENC_MODREGRM_RM_IMM, OPND_ENC_REG_IMM,
                               OPND_ENC_EAX_IMM, OPND_ENC_MODREGRM_REG_RM_IMM,
                               OPND_ENC_MODREGRM_RM_REG_IMM};
        r.imm_len = !has_imm ? 3'd0 : (opnd16 ? 3'd2 : (imm8 ? 3'd1 : 3'd4));
        r.instr_len = 4'd1 + 4'(r.has_modrm) + 4'(r.has_sib)
                    + 4'(r.disp_len) + 4'(r.imm_len);
        return r;
    endfunction

    // Little-endian byte select out of a 32-bit field.
    function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

endpackage

// File: rtl/encode_opnd_bytes_len.sv
// Purely combinational length calculator for the operand byte encoder.
module encode_opnd_len
    import encode_opnd_bytes_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic [3:0]       i_form,
    input  logic [1:0]       i_mod,
    input  logic [2:0]       i_rm,
    input  logic [2:0]       i_sib_base,
    input  logic             i_addr16,
    input  logic             i_opnd16,
    input  logic             i_imm8,
    output logic             o_has_modrm,
    output logic             o_has_sib,
    output logic [2:0]       o_disp_len,
    output logic [2:0]       o_imm_len,
    output logic [LEN_W-1:0] o_instr_len
);

    opnd_len_t w_len;

    // Evaluate the shared length rules on the live request fields.
    always_comb begin
        w_len       = calc_opnd_len(i_form, i_mod, i_rm, i_sib_base, i_addr16, i_opnd16, i_imm8);
        o_has_modrm = w_len.has_modrm;
        o_has_sib   = w_len.has_sib;
        o_disp_len  = w_len.disp_len;
        o_imm_len   = w_len.imm_len;
        o_instr_len = LEN_W'(w_len.instr_len);
    end

endmodule

// File: rtl/encode_opnd_bytes.sv
// Operand byte encoder: serializes opcode, ModR/M, SIB, displacement and
// immediate of one instruction into a valid/ready byte stream.
// Optional feature macro ENCODE_PACKED_INSTR_EN adds instr_packed/instr_done,
// a packed copy of the emitted instruction for direct use by the decoder.
module encode_opnd_bytes
    import encode_opnd_bytes_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       opcode,
    input  logic [3:0]       opnd_form,
    input  logic [7:0]       modrm,
    input  logic [7:0]       sib,
    input  logic [31:0]      disp,
    input  logic [31:0]      imm,
    input  logic             prefix_address_16bit,
    input  logic             prefix_operand_16bit,
    input  logic             imm_1byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             out_last,
    output logic [LEN_W-1:0] instr_len
`ifdef ENCODE_PACKED_INSTR_EN
    ,
    output logic [87:0]      instr_packed,
    output logic             instr_done
`endif
);

    logic             w_has_modrm;
    logic             w_has_sib;
    logic [2:0]       w_disp_len;
    logic [2:0]       w_imm_len;
    logic [LEN_W-1:0] w_instr_len;

    enc_state_t       r_state;
    logic             r_req_ready;
    logic             r_out_valid;
    logic [7:0]       r_out_byte;
    logic             r_out_last;
    logic [LEN_W-1:0] r_instr_len;
    logic [LEN_W-1:0] r_remaining;
    logic [1:0]       r_cnt;
    logic [7:0]       r_modrm;
    logic [7:0]       r_sib;
    logic [31:0]      r_disp;
    logic [31:0]      r_imm;
    logic             r_has_modrm;
    logic             r_has_sib;
    logic [2:0]       r_disp_len;
    logic [2:0]       r_imm_len;

    enc_state_t       w_nstate;
    logic [1:0]       w_ncnt;
    logic [7:0]       w_nbyte;

    encode_opnd_len #(.LEN_W(LEN_W)) u_len (
        .i_form      (opnd_form),
        .i_mod       (modrm[7:6]),
        .i_rm        (modrm[2:0]),
        .i_sib_base  (sib[2:0]),
        .i_addr16    (prefix_address_16bit),
        .i_opnd16    (prefix_operand_16bit),
        .i_imm8      (imm_1byte),
        .o_has_modrm (w_has_modrm),
        .o_has_sib   (w_has_sib),
        .o_disp_len  (w_disp_len),
        .o_imm_len   (w_imm_len),
        .o_instr_len (w_instr_len)
    );

    // Pick the field and byte that follow the one currently presented,
    // skipping fields of zero length.
    always_comb begin
        w_nstate = ST_IDLE;
        w_ncnt   = 2'd0;
        if ((r_state == ST_DISP && {1'b0, r_cnt} != r_disp_len - 3'd1) ||
            (r_state == ST_IMM  && {1'b0, r_cnt} != r_imm_len  - 3'd1)) begin
            w_nstate = r_state;
            w_ncnt   = r_cnt + 2'd1;
        end else if (r_state == ST_OPC && r_has_modrm) begin
            w_nstate = ST_MODRM;
        end else if (r_state inside {ST_OPC, ST_MODRM} && r_has_sib) begin
            w_nstate = ST_SIB;
        end else if (r_state inside {ST_OPC, ST_MODRM, ST_SIB} && r_disp_len != 3'd0) begin
            w_nstate = ST_DISP;
        end else if (r_state != ST_IMM && r_imm_len != 3'd0) begin
            w_nstate = ST_IMM;
        end
        case (w_nstate)
            ST_MODRM: w_nbyte = r_modrm;
            ST_SIB:   w_nbyte = r_sib;
            ST_DISP:  w_nbyte = sel_byte(r_disp, w_ncnt);
            ST_IMM:   w_nbyte = sel_byte(r_imm, w_ncnt);
            default:  w_nbyte = 8'h00;
        endcase
    end

    // Main FSM: accept a request, then step one byte per output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_byte  <= 8'h00;
            r_out_last  <= 1'b0;
            r_instr_len <= '0;
            r_remaining <= '0;
            r_cnt       <= 2'd0;
            r_modrm     <= 8'h00;
            r_sib       <= 8'h00;
            r_disp      <= 32'h0;
            r_imm       <= 32'h0;
            r_has_modrm <= 1'b0;
            r_has_sib   <= 1'b0;
            r_disp_len  <= 3'd0;
            r_imm_len   <= 3'd0;
        end else if (r_state == ST_IDLE) begin
            if (req_valid) begin
                r_state     <= ST_OPC;
                r_req_ready <= 1'b0;
                r_out_valid <= 1'b1;
                r_out_byte  <= opcode;
                r_out_last  <= (w_instr_len == LEN_W'(1));
                r_instr_len <= w_instr_len;
                r_remaining <= w_instr_len;
                r_cnt       <= 2'd0;
                r_modrm     <= modrm;
                r_sib       <= sib;
                r_disp      <= disp;
                r_imm       <= imm;
                r_has_modrm <= w_has_modrm;
                r_has_sib   <= w_has_sib;
                r_disp_len  <= w_disp_len;
                r_imm_len   <= w_imm_len;
            end
        end else if (out_ready) begin
            if (r_out_last) begin
                r_state     <= ST_IDLE;
                r_req_ready <= 1'b1;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_cnt       <= 2'd0;
                r_remaining <= '0;
            end else begin
                r_state     <= w_nstate;
                r_cnt       <= w_ncnt;
                r_out_byte  <= w_nbyte;
                r_out_last  <= (r_remaining == LEN_W'(2));
                r_remaining <= r_remaining - LEN_W'(1);
            end
        end
    end

    assign req_ready = r_req_ready;
    assign out_valid = r_out_valid;
    assign out_byte  = r_out_byte;
    assign out_last  = r_out_last;
    assign instr_len = r_instr_len;

`ifdef ENCODE_PACKED_INSTR_EN
    logic [87:0]      r_instr_packed;
    logic             r_instr_done;
    logic [LEN_W-1:0] w_idx;

    assign w_idx = r_instr_len - r_remaining;

    // Mirror each emitted byte into the packed image; flag completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_packed <= '0;
            r_instr_done   <= 1'b0;
        end else begin
            r_instr_done <= 1'b0;
            if (r_state == ST_IDLE && req_valid) begin
                r_instr_packed <= '0;
            end else if (r_out_valid && out_ready) begin
                r_instr_packed[{w_idx, 3'b000} +: 8] <= r_out_byte;
                r_instr_done <= r_out_last;
            end
        end
    end

    assign instr_packed = r_instr_packed;
    assign instr_done   = r_instr_done;
`endif

endmodule

// File: tb/tb_encode_opnd_bytes.sv
// Scoreboard bench for encode_opnd_bytes with a queue-based reference model.
module tb_encode_opnd_bytes;
    import encode_opnd_bytes_pkg::*;

    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [7:0]       opcode = 8'h00;
    logic [3:0]       opnd_form = 4'h0;
    logic [7:0]       modrm = 8'h00;
    logic [7:0]       sib = 8'h00;
    logic [31:0]      disp = 32'h0;
    logic [31:0]      imm = 32'h0;
    logic             prefix_address_16bit = 1'b0;
    logic             prefix_operand_16bit = 1'b0;
    logic             imm_1byte = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [7:0]       out_byte;
    logic             out_last;
    logic [LEN_W-1:0] instr_len;
`ifdef ENCODE_PACKED_INSTR_EN
    logic [87:0]      instr_packed;
    logic             instr_done;
`endif

    int errors = 0;
    int checks = 0;
    int mon_cnt = 0;
    int hold_cnt = 0;
    bit rand_ready = 1'b0;

    logic [7:0] exp_b[$];
    logic       exp_l[$];

    bit         hold_flag = 1'b0;
    logic [7:0] hold_b;
    logic       hold_l;

    encode_opnd_bytes #(.LEN_W(LEN_W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .opcode               (opcode),
        .opnd_form            (opnd_form),
        .modrm                (modrm),
        .sib                  (sib),
        .disp                 (disp),
        .imm                  (imm),
        .prefix_address_16bit (prefix_address_16bit),
        .prefix_operand_16bit (prefix_operand_16bit),
        .imm_1byte            (imm_1byte),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_byte             (out_byte),
        .out_last             (out_last),
        .instr_len            (instr_len)
`ifdef ENCODE_PACKED_INSTR_EN
        ,
        .instr_packed         (instr_packed),
        .instr_done           (instr_done)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: list the instruction's bytes from the field rules.
    task automatic build(input logic [7:0] op, input logic [3:0] f, input logic [7:0] m,
                         input logic [7:0] s, input logic [31:0] d, input logic [31:0] i,
                         input bit a16, input bit o16, input bit i1,
                         output int len, output logic [87:0] pk);
        logic [7:0] bytes[$];
        int md, rm, dl, il;
        bit hm, hs, d8, d32, hi;
        md = int'(m[7:6]);
        rm = int'(m[2:0]);
        hm = f inside {OPND_ENC_MODREGRM_RM, OPND_ENC_MODREGRM_RM_IMM, OPND_ENC_MODREGRM_RM_REG,
                       OPND_ENC_MODREGRM_RM_REG_IMM, OPND_ENC_MODREGRM_RM_REG_CL,
                       OPND_ENC_MODREGRM_RM_CL, OPND_ENC_MODREGRM_REG_RM,
                       OPND_ENC_MODREGRM_REG_RM_IMM};
        hs  = hm && !a16 && md != 3 && rm == 4;
        d32 = (f == OPND_ENC_DISP32) || (hm && md == 0 && rm == 5) || (hm && md == 2)
              || (hs && s[2:0] == 3'd5 && md != 1);
        d8  = (f == OPND_ENC_DISP8) || (hm && md == 1);
        dl  = d32 ? 4 : (d8 ? 1 : 0);
        hi  = f inside {OPND_ENC_IMM, OPND_ENC_MODREGRM_RM_IMM, OPND_ENC_REG_IMM, OPND_ENC_EAX_IMM,
                        OPND_ENC_MODREGRM_REG_RM_IMM, OPND_ENC_MODREGRM_RM_REG_IMM};
        il  = !hi ? 0 : (o16 ? 2 : (i1 ? 1 : 4));
        bytes.push_back(op);
        if (hm) bytes.push_back(m);
        if (hs) bytes.push_back(s);
        for (int k = 0; k < dl; k++) bytes.push_back(8'((d >> (8 * k)) & 32'hFF));
        for (int k = 0; k < il; k++) bytes.push_back(8'((i >> (8 * k)) & 32'hFF));
        len = bytes.size();
        pk  = '0;
        for (int k = 0; k < len; k++) begin
            exp_b.push_back(bytes[k]);
            exp_l.push_back(k == len - 1);
            pk = pk | (88'(bytes[k]) << (8 * k));
        end
    endtask

    // Output-ready driver: changes well away from the sampling edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (hold_cnt > 0) begin
                out_ready = 1'b0;
                hold_cnt--;
            end else if (rand_ready) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            hold_flag = 1'b0;
        end else begin
            if (hold_flag) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_byte", out_byte, hold_b);
                chk("stall_last", out_last, hold_l);
                hold_flag = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_b.size() == 0) begin
                    chk("unexpected_byte", out_byte, 88'hFFF);
                end else begin
                    chk("byte", out_byte, exp_b.pop_front());
                    chk("last", out_last, exp_l.pop_front());
                end
                mon_cnt++;
            end else if (out_valid) begin
                hold_flag = 1'b1;
                hold_b    = out_byte;
                hold_l    = out_last;
            end
        end
    end

    task automatic drive(input logic [7:0] op, input logic [3:0] f, input logic [7:0] m,
                         input logic [7:0] s, input logic [31:0] d, input logic [31:0] i,
                         input bit a16, input bit o16, input bit i1);
        opcode = op; opnd_form = f; modrm = m; sib = s; disp = d; imm = i;
        prefix_address_16bit = a16; prefix_operand_16bit = o16; imm_1byte = i1;
    endtask

    task automatic send(input logic [7:0] op, input logic [3:0] f, input logic [7:0] m,
                        input logic [7:0] s, input logic [31:0] d, input logic [31:0] i,
                        input bit a16, input bit o16, input bit i1, input bit junk);
        int len, t;
        logic [87:0] pk;
        build(op, f, m, s, d, i, a16, o16, i1, len, pk);
        @(negedge clk);
        t = 0;
        while (!req_ready && t < 100) begin @(negedge clk); t++; end
        chk("idle_before_req", req_ready, 1'b1);
        drive(op, f, m, s, d, i, a16, o16, i1);
        req_valid = 1'b1;
        @(negedge clk);
        chk("first_byte_valid", out_valid, 1'b1);
        chk("instr_len", instr_len, len);
        chk("busy_not_ready", req_ready, 1'b0);
        if (junk) begin
            drive(8'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), $urandom, $urandom,
                  1'($urandom), 1'($urandom), 1'($urandom));
        end else begin
            req_valid = 1'b0;
        end
        t = 0;
        while (!(out_valid && out_ready && out_last) && t < 200) begin @(negedge clk); t++; end
        chk("last_handshake_seen", out_valid && out_ready && out_last, 1'b1);
        req_valid = 1'b0;
        @(negedge clk);
        chk("turnaround_ready", req_ready, 1'b1);
        chk("idle_valid", out_valid, 1'b0);
        chk("len_held", instr_len, len);
`ifdef ENCODE_PACKED_INSTR_EN
        chk("instr_done", instr_done, 1'b1);
        chk("instr_packed", instr_packed, pk);
`endif
    endtask

    initial begin
        int len, t, base;
        logic [87:0] pk;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_byte", out_byte, 8'h00);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_instr_len", instr_len, 4'd0);
        rst = 1'b0;

        send(8'h89, OPND_ENC_MODREGRM_RM_REG, 8'h45, 8'h00, 32'h10, 32'h0, 0, 0, 0, 0);
        send(8'h89, OPND_ENC_MODREGRM_RM_REG, 8'h04, 8'h25, 32'h12345678, 32'h0, 0, 0, 0, 0);
        send(8'h89, OPND_ENC_MODREGRM_RM_REG, 8'h04, 8'h25, 32'h12345678, 32'h0, 1, 0, 0, 0);
        send(8'h81, OPND_ENC_MODREGRM_RM_IMM, 8'hC0, 8'h00, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0);
        send(8'h81, OPND_ENC_MODREGRM_RM_IMM, 8'hC0, 8'h00, 32'h0, 32'hDEADBEEF, 0, 1, 0, 0);
        send(8'h81, OPND_ENC_MODREGRM_RM_IMM, 8'hC0, 8'h00, 32'h0, 32'hDEADBEEF, 0, 0, 1, 0);
        send(8'h90, OPND_ENC_NONE, 8'h00, 8'h00, 32'h0, 32'h0, 0, 0, 0, 0);
        send(8'hC7, OPND_ENC_MODREGRM_RM_IMM, 8'h84, 8'h05, 32'hA1B2C3D4, 32'h11223344, 0, 0, 0, 0);

        // Backpressure mid-displacement with request noise while busy.
        base = mon_cnt;
        fork
            send(8'h89, OPND_ENC_MODREGRM_RM_REG, 8'h04, 8'h25, 32'h12345678, 32'h0, 0, 0, 0, 1);
            begin
                t = 0;
                while (mon_cnt < base + 4 && t < 50) begin @(negedge clk); t++; end
                hold_cnt = 3;
            end
        join

        // Reset after two bytes of a seven-byte instruction.
        @(negedge clk);
        build(8'h89, OPND_ENC_MODREGRM_RM_REG, 8'h04, 8'h25, 32'h12345678, 32'h0, 0, 0, 0, len, pk);
        drive(8'h89, OPND_ENC_MODREGRM_RM_REG, 8'h04, 8'h25, 32'h12345678, 32'h0, 0, 0, 0);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_req_ready", req_ready, 1'b1);
        chk("midrst_out_last", out_last, 1'b0);
        rst = 1'b0;
        exp_b.delete();
        exp_l.delete();
        send(8'h8B, OPND_ENC_MODREGRM_REG_RM, 8'h85, 8'h00, 32'hCAFEF00D, 32'h0, 0, 0, 0, 0);

        // Randomized requests under random output backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            send(8'($urandom), 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                 $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom));
        end
        rand_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
